fifo_umbral_param: RTL

Parametrised synchronous FIFO: the next generation of the team's main-queue FIFO.
- Generalised in data width and depth.
- Adds runtime-programmable almost-full/almost-empty thresholds, a full-range occupancy count and a sticky overflow/underflow error with clear.
- Adds a selectable output mode: registered read or first-word-fall-through (FWFT).
- Sits between a producer and consumer in the datapath, in place of the fixed main FIFO.

---
 rtl/fifo_umbral_param.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fifo_umbral_param.sv
// fifo_umbral_param
// Parametrised synchronous FIFO with runtime-programmable almost-full and
// almost-empty thresholds, a full-range occupancy count, a sticky
// overflow/underflow error with synchronous clear, and a selectable output
// mode: registered read (FWFT=0) or first-word-fall-through (FWFT=1).
//
// Ports:
//   clk              in   rising-edge clock
//   reset_L          in   asynchronous active-low reset
//   write            in   push request
//   read             in   pop request
//   buff_in          in   push data [DATA_SIZE]
//   umb_almost_full  in   almost-full threshold [ADDR_SIZE+1]
//   umb_almost_empty in   almost-empty threshold [ADDR_SIZE+1]
//   error_clr        in   synchronous clear of the sticky error
//   buffer_out       out  pop data [DATA_SIZE]
//   valid_out        out  buffer_out holds valid data
//   fifo_full        out  occupancy == DEPTH
//   fifo_empty       out  occupancy == 0
//   almost_full      out  occupancy >= umb_almost_full
//   almost_empty     out  occupancy <= umb_almost_empty
//   data_count       out  occupancy, 0..DEPTH [ADDR_SIZE+1]
//   error            out  sticky overflow/underflow flag
module fifo_umbral_param #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 3,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 write,
  input  logic                 read,
  input  logic [DATA_SIZE-1:0] buff_in,
  input  logic [ADDR_SIZE:0]   umb_almost_full,
  input  logic [ADDR_SIZE:0]   umb_almost_empty,
  input  logic                 error_clr,
  output logic [DATA_SIZE-1:0] buffer_out,
  output logic                 valid_out,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   data_count,
  output logic                 error
);

  localparam int                   DEPTH     = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0]   CNT_FULL  = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0]   CNT_ZERO  = (ADDR_SIZE+1)'(32'd0);
  localparam logic [ADDR_SIZE:0]   CNT_ONE   = (ADDR_SIZE+1)'(32'd1);
  localparam logic [ADDR_SIZE-1:0] PTR_ZERO  = ADDR_SIZE'(32'd0);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE   = ADDR_SIZE'(32'd1);
  localparam logic [DATA_SIZE-1:0] DATA_ZERO = DATA_SIZE'(32'd0);

  logic [DATA_SIZE-1:0] mem_r [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr_r;
  logic [ADDR_SIZE-1:0] rd_ptr_r;
  logic [ADDR_SIZE:0]   count_r;
  logic [ADDR_SIZE:0]   count_nxt_s;
  logic                 error_r;
  logic                 error_nxt_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 rd_acc_s;
  logic                 wr_acc_s;
  logic                 overflow_s;
  logic                 underflow_s;

  // Occupancy flags and accept logic. Full and empty come only from the
  // count, since the pointers alone cannot tell them apart after wrapping.
  // A push into a full FIFO is accepted only alongside an accepted pop.
  always_comb begin
    full_s      = (count_r == CNT_FULL);
    empty_s     = (count_r == CNT_ZERO);
    rd_acc_s    = read & ~empty_s;
    wr_acc_s    = write & (~full_s | rd_acc_s);
    overflow_s  = write & full_s & ~rd_acc_s;
    underflow_s = read & empty_s;
  end

  // Next occupancy: simultaneous accepted push and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Sticky error: a new event in the same cycle as error_clr wins.
  always_comb begin
    error_nxt_s = error_r;
    if (overflow_s | underflow_s) begin
      error_nxt_s = 1'b1;
    end else if (error_clr) begin
      error_nxt_s = 1'b0;
    end else begin
      error_nxt_s = error_r;
    end
  end

  // Pointer, occupancy and error state.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      error_r  <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      error_r <= error_nxt_s;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= buff_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown combinationally whenever the FIFO holds data.
      always_comb begin
        buffer_out = DATA_ZERO;
        valid_out  = 1'b0;
        if (!empty_s) begin
          buffer_out = mem_r[rd_ptr_r];
          valid_out  = 1'b1;
        end else begin
          buffer_out = DATA_ZERO;
          valid_out  = 1'b0;
        end
      end
    end else begin : g_registered
      logic [DATA_SIZE-1:0] out_r;
      logic                 valid_r;

      // Registered read: data appears the cycle after the accepted pop and
      // holds its last value afterwards; valid lasts exactly one cycle.
      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          out_r   <= DATA_ZERO;
          valid_r <= 1'b0;
        end else begin
          valid_r <= rd_acc_s;
          if (rd_acc_s) begin
            out_r <= mem_r[rd_ptr_r];
          end
        end
      end

      assign buffer_out = out_r;
      assign valid_out  = valid_r;
    end
  endgenerate

  assign fifo_full    = full_s;
  assign fifo_empty   = empty_s;
  assign almost_full  = (count_r >= umb_almost_full);
  assign almost_empty = (count_r <= umb_almost_empty);
  assign data_count   = count_r;
  assign error        = error_r;

endmodule
